// File: rtl/config_pkg.sv
// Shared widths and types for the operand path.
package config_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OF_DEPTH = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers. The head is gated to zero when empty.
module sync_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output T     head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PtrOne = (PTR_W + 1)'(1);

  logic [PTR_W:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic           do_push, do_pop;
  T               mem_q [DEPTH];

  // Status flags, guarded push/pop and next pointer values
  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
              (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wptr_d  = do_push ? wptr_q + PtrOne : wptr_q;
    rptr_d  = do_pop ? rptr_q + PtrOne : rptr_q;
    head_o  = '0;
    if (!empty_o) head_o = mem_q[rptr_q[PTR_W-1:0]];
  end

  // Pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset; the head is masked while empty
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/operand_fetch.sv
// Issues one memory read per accepted address and returns the data in order.
// Credits cover pending request + outstanding reads + buffered words, so the
// non-back-pressurable response stream can never overflow the buffer.
module operand_fetch
  import config_pkg::*;
#(
  parameter int unsigned DEPTH = OF_DEPTH
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  addr_t rd_addr_i,
  input  logic  rd_addr_valid_i,
  output logic  rd_addr_ready_o,
  output logic  mem_req_o,
  output addr_t mem_addr_o,
  input  logic  mem_gnt_i,
  input  logic  mem_rvalid_i,
  input  data_t mem_rdata_i,
  output data_t data_o,
  output logic  data_valid_o,
  input  logic  data_ready_i,
  output logic  err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             mem_req_q, mem_req_d;
  addr_t            mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0] credits_q, credits_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             err_q, err_d;
  logic             accept, pop, issue, push, fifo_full, fifo_empty;

  sync_fifo #(
    .T     (data_t),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (mem_rdata_i),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (data_o)
  );

  // Handshake decode; a pop frees its credit for an accept in the same cycle
  always_comb begin
    data_valid_o    = !fifo_empty;
    pop             = data_valid_o && data_ready_i;
    issue           = mem_req_q && mem_gnt_i;
    push            = mem_rvalid_i && (outst_q != '0);
    rd_addr_ready_o = !rst_i && ((credits_q < CntMax) || pop) && (!mem_req_q || mem_gnt_i);
    accept          = rd_addr_valid_i && rd_addr_ready_o;
    mem_req_o       = mem_req_q;
    mem_addr_o      = mem_addr_q;
    err_o           = err_q;
  end

  // Next state for request register, counters and sticky error
  always_comb begin
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if (accept) begin
      mem_req_d  = 1'b1;
      mem_addr_d = rd_addr_i;
    end else if (issue) begin
      mem_req_d  = 1'b0;
    end

    credits_d = credits_q;
    if (accept && !pop)      credits_d = credits_q + CntOne;
    else if (!accept && pop) credits_d = credits_q - CntOne;

    outst_d = outst_q;
    if (issue && !push)      outst_d = outst_q + CntOne;
    else if (!issue && push) outst_d = outst_q - CntOne;

    // A response with nothing outstanding is dropped and flagged
    err_d = err_q || (mem_rvalid_i && (outst_q == '0));
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      credits_q  <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      credits_q  <= credits_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
    end
  end

  a_credits_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    credits_q <= CntMax);
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_full));
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_req_q && !mem_gnt_i) |=> (mem_req_q && $stable(mem_addr_q)));

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed table, corner sequences and random traffic
// checked against a queue-based model of the stage.
module tb_operand_fetch;
  import config_pkg::*;

  localparam int DEPTH = 4;

  logic  clk = 1'b0;
  logic  rst, v, gnt, rvalid, dr;
  addr_t addr;
  data_t rdata;
  logic  rd_addr_ready_o, mem_req_o, data_valid_o, err_o;
  addr_t mem_addr_o;
  data_t data_o;

  operand_fetch #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .rd_addr_i       (addr),
    .rd_addr_valid_i (v),
    .rd_addr_ready_o (rd_addr_ready_o),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (gnt),
    .mem_rvalid_i    (rvalid),
    .mem_rdata_i     (rdata),
    .data_o          (data_o),
    .data_valid_o    (data_valid_o),
    .data_ready_i    (dr),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory side: granted reads come back in order after a latency
  typedef struct { int due; data_t data; } rsp_t;
  rsp_t resp_q[$];
  int   last_due = 0;
  int   lat = 2;

  // Stage model
  bit    m_req, m_err, m_rst_state, m_acc, er;
  addr_t m_addr;
  int    m_credits, m_out;
  data_t m_fifo[$];
  int    dut_acc, dut_pop, acc_now, m_acc_total;

  typedef struct {
    logic v; addr_t a; logic g; logic rv; data_t rd; logic dr;
    logic e_rdy; logic e_req; addr_t e_addr; logic e_dv; data_t e_data; logic e_err;
  } vec_t;
  vec_t tbl[9];

  function automatic data_t mem_word(input addr_t a);
    return {a ^ 16'hBEEF, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void clear_model();
    m_req = 1'b0; m_addr = '0; m_credits = 0; m_out = 0; m_err = 1'b0;
    m_fifo.delete();
  endfunction

  // One clock: memory response, output checks, model update at the edge
  task automatic step();
    bit pop_m;
    int old_out;
    int due;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = resp_q[0].data;
      void'(resp_q.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = data_t'($urandom);
    end
    #4;
    pop_m = !rst && (m_fifo.size() > 0) && dr;
    er    = !rst && ((m_credits < DEPTH) || pop_m) && (!m_req || gnt);
    chk("ready", rd_addr_ready_o, er);
    chk("req", mem_req_o, m_req);
    if (m_req) chk("mem_addr", mem_addr_o, m_addr);
    chk("dvalid", data_valid_o, m_fifo.size() > 0);
    if (m_fifo.size() > 0) chk("data", data_o, m_fifo[0]);
    chk("err", err_o, m_err);
    if (m_rst_state) begin
      chk("rst mem_addr", mem_addr_o, 0);
      chk("rst data", data_o, 0);
    end
    acc_now = (v && rd_addr_ready_o) ? 1 : 0;
    dut_acc += acc_now;
    if (data_valid_o && dr) dut_pop++;
    @(posedge clk);
    m_acc = 1'b0;
    if (rst) begin
      clear_model();
      m_rst_state = 1'b1;
    end else begin
      m_rst_state = 1'b0;
      m_acc = v && er;
      if (m_acc) m_acc_total++;
      old_out = m_out;
      if (m_req && gnt) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        resp_q.push_back('{due, mem_word(m_addr)});
        m_out++;
      end
      if (pop_m) void'(m_fifo.pop_front());
      if (rvalid) begin
        if (old_out > 0) begin
          m_out--;
          m_fifo.push_back(rdata);
        end else begin
          m_err = 1'b1;
        end
      end
      m_credits += int'(m_acc) - int'(pop_m);
      if (m_acc) begin
        m_req  = 1'b1;
        m_addr = addr;
      end else if (gnt) begin
        m_req = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  // Unchecked reset edge, used when the model cannot know the DUT state
  task automatic reset_raw();
    rst = 1'b1; v = 1'b0; gnt = 1'b0; rvalid = 1'b0; dr = 1'b0;
    @(posedge clk);
    clear_model();
    resp_q.delete();
    m_rst_state = 1'b1;
    cyc++;
    #1;
  endtask

  int n_acc;

  initial begin
    addr = '0; rdata = '0;
    tbl[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 32'h0,  1'b0};
    tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 16'h0010, 1'b0, 32'h0,  1'b0};
    tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 32'h0,  1'b0};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 32'h0,  1'b0};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 16'h0,    1'b1, 32'hA5, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 32'h0,  1'b0};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 32'h0,  1'b0};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 32'h0,  1'b1};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 32'h0,  1'b1};

    @(posedge clk); #1;

    // Reset held 3 cycles with random inputs, then first accept possible
    reset_raw();
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1; v = 1'($urandom); addr = addr_t'($urandom);
      gnt = 1'($urandom); dr = 1'($urandom);
      step();
    end
    rst = 1'b0; v = 1'b0; gnt = 1'b0; dr = 1'b1;
    step();

    // Single read and stray response, directed table
    for (int i = 0; i < 9; i++) begin
      v = tbl[i].v; addr = tbl[i].a; gnt = tbl[i].g;
      rvalid = tbl[i].rv; rdata = tbl[i].rd; dr = tbl[i].dr; rst = 1'b0;
      #4;
      chk("tbl ready", rd_addr_ready_o, tbl[i].e_rdy);
      chk("tbl req", mem_req_o, tbl[i].e_req);
      if (tbl[i].e_req) chk("tbl mem_addr", mem_addr_o, tbl[i].e_addr);
      chk("tbl dvalid", data_valid_o, tbl[i].e_dv);
      if (tbl[i].e_dv) chk("tbl data", data_o, tbl[i].e_data);
      chk("tbl err", err_o, tbl[i].e_err);
      @(posedge clk); #1;
      cyc++;
    end
    reset_raw();
    rst = 1'b1; step();
    rst = 1'b0; v = 1'b0; dr = 1'b1; gnt = 1'b1;
    step();

    // Stream of 8 reads, full throughput
    lat = 2; gnt = 1'b1; dr = 1'b1; dut_pop = 0;
    for (int k = 0; k < 8; k++) begin
      v = 1'b1; addr = addr_t'(16'h0100 + k);
      step();
      chk("stream accept", acc_now, 1);
    end
    v = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("stream words", dut_pop, 8);

    // Consumer stalled: only DEPTH reads accepted, pop reopens the input
    dr = 1'b0; gnt = 1'b1; lat = 2; dut_acc = 0; n_acc = 0;
    for (int k = 0; k < 12; k++) begin
      v = (n_acc < 6); addr = addr_t'(16'h0200 + n_acc);
      step();
      if (m_acc) n_acc++;
    end
    chk("full accepted", dut_acc, 4);
    chk("full ready low", rd_addr_ready_o, 0);
    dr = 1'b1;
    #1;
    chk("ready on pop", rd_addr_ready_o, 1);
    for (int k = 0; k < 20; k++) begin
      v = (n_acc < 6); addr = addr_t'(16'h0200 + n_acc);
      step();
      if (m_acc) n_acc++;
    end
    chk("full total accepted", dut_acc, 6);

    // Grant stalled 3 cycles: request and address frozen
    v = 1'b1; addr = 16'h0020; gnt = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      v = 1'b1; addr = 16'h0099; gnt = 1'b0;
      step();
      chk("stall addr", mem_addr_o, 16'h0020);
      chk("stall req", mem_req_o, 1);
    end
    v = 1'b0; gnt = 1'b1;
    for (int k = 0; k < 6; k++) step();

    // Reset mid-stream, late responses become stray
    lat = 4; gnt = 1'b1; dr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v = 1'b1; addr = addr_t'(16'h0300 + k);
      step();
    end
    v = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("stray err", err_o, 1);
    chk("stray no data", data_valid_o, 0);
    rst = 1'b1; step();
    rst = 1'b0; step();
    chk("err cleared", err_o, 0);

    // Random traffic
    dut_pop = 0; m_acc_total = 0;
    for (int k = 0; k < 400; k++) begin
      v    = 1'($urandom_range(0, 1));
      addr = addr_t'($urandom);
      gnt  = ($urandom_range(0, 99) < 70);
      dr   = ($urandom_range(0, 99) < 60);
      lat  = $urandom_range(1, 4);
      step();
    end
    v = 1'b0; gnt = 1'b1; dr = 1'b1;
    for (int k = 0; k < 30; k++) step();
    chk("random words out", dut_pop, m_acc_total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
